// File: rtl/wb_mem_pkg.sv
// Shared definitions for the banked Wishbone memory controller:
// FSM state encoding, default parameter values and index-width helper.
package wb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DEPTH     = 256;
  localparam int DEF_NUM_BANKS = 2;
  localparam int DEF_WAIT_CYC  = 1;

  // Width of an index selecting one of n items; never narrower than one bit.
  function automatic int bank_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_mem_bank.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port (read-before-write on a same-address access).
module wb_mem_bank
  import wb_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [DATA_W/8-1:0]           be,
  input  logic [bank_idx_w(DEPTH)-1:0]  addr,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);

  localparam int NUM_LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane masked write plus registered read of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_banked_mem_ctrl.sv
// Wishbone slave in front of NUM_BANKS independent byte-enabled RAM banks.
// Each transfer runs IDLE -> (WAIT x WAIT_CYC) -> RESP -> IDLE; out-of-range
// bank or address terminates with err and touches neither memory nor DAT_O.
module wb_banked_mem_ctrl
  import wb_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int WAIT_CYC  = DEF_WAIT_CYC
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cyc,
  input  logic                              stb,
  input  logic                              we,
  input  logic [DATA_W/8-1:0]               sel,
  input  logic [bank_idx_w(NUM_BANKS)-1:0]  core_select,
  input  logic [ADDR_W-1:0]                 ADR_I,
  input  logic [DATA_W-1:0]                 DAT_I,
  output logic [DATA_W-1:0]                 DAT_O,
  output logic                              ack,
  output logic                              err
);

  localparam int CSW = bank_idx_w(NUM_BANKS);
  localparam int BAW = bank_idx_w(DEPTH);

  state_t                 state_reg;
  logic [3:0]             wait_cnt_reg;
  logic [BAW-1:0]         adr_reg;
  logic [CSW-1:0]         cs_reg;
  logic                   we_reg;
  logic [DATA_W/8-1:0]    sel_reg;
  logic [DATA_W-1:0]      dat_reg;
  logic                   ok_reg;
  logic                   ack_reg;
  logic                   err_reg;
  logic [DATA_W-1:0]      dat_hold_reg;

  logic                   req;
  logic                   req_ok;
  logic                   bank_we;
  logic                   resp_rd;
  logic [BAW-1:0]         bank_addr;
  logic [DATA_W-1:0]      rd_word;
  logic [DATA_W-1:0]      bank_rdata [NUM_BANKS];

  assign req = cyc & stb;

  // Range check done on the live request so the verdict is latched with it.
  // Compare one bit wider so a limit equal to 2**width is representable.
  assign req_ok = ({1'b0, ADR_I} < (ADDR_W + 1)'(DEPTH)) &&
                  ({1'b0, core_select} < (CSW + 1)'(NUM_BANKS));

  // The master only sees a termination while it still drives the cycle,
  // so dropping cyc in RESP silently cancels the response.
  assign ack = ack_reg & req;
  assign err = err_reg & req;

  // Commit happens on the edge that ends RESP, and only if the cycle survived.
  assign bank_we = (state_reg == RESP) && req && we_reg && ok_reg;
  assign resp_rd = (state_reg == RESP) && req && !we_reg && ok_reg;

  // In IDLE the RAM looks at the live address so that the read word is ready
  // one edge later, which is what makes WAIT_CYC=0 work with a registered RAM.
  assign bank_addr = (state_reg == IDLE) ? ADR_I[BAW-1:0] : adr_reg;

  // Transfer sequencing, request capture and registered termination flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      adr_reg      <= '0;
      cs_reg       <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= '0;
      dat_reg      <= '0;
      ok_reg       <= 1'b0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            adr_reg <= ADR_I[BAW-1:0];
            cs_reg  <= core_select;
            we_reg  <= we;
            sel_reg <= sel;
            dat_reg <= DAT_I;
            ok_reg  <= req_ok;
            if (WAIT_CYC == 0) begin
              state_reg <= RESP;
              ack_reg   <= req_ok;
              err_reg   <= !req_ok;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= 4'(WAIT_CYC);
            end
          end
        end
        WAIT: begin
          if (!cyc) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
          end else if (wait_cnt_reg == 4'd1) begin
            state_reg    <= RESP;
            wait_cnt_reg <= 4'd0;
            ack_reg      <= ok_reg;
            err_reg      <= !ok_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Keep the most recent successfully read word for DAT_O outside of read acks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_hold_reg <= '0;
    end else if (resp_rd) begin
      dat_hold_reg <= rd_word;
    end
  end

  // Select the read word of the latched bank; an invalid bank yields zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (cs_reg == CSW'(i)) begin
        rd_word = bank_rdata[i];
      end
    end
  end

  assign DAT_O = resp_rd ? rd_word : dat_hold_reg;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    wb_mem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we && (cs_reg == CSW'(gi))),
      .be    (sel_reg),
      .addr  (bank_addr),
      .wdata (dat_reg),
      .rdata (bank_rdata[gi])
    );
  end

endmodule

// File: doc/wb_banked_mem_ctrl.md
WB_BANKED_MEM_CTRL -- requirements
Module: wb_banked_mem_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W, 32, data bus width in bits (multiple of 8)
  ADDR_W, 32, word-address bus width
  DEPTH, 256, words per bank
  NUM_BANKS, 2, independent memory banks selected by core_select
  WAIT_CYC, 1, wait states inserted before each response (0..15)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk, input, 1, single clock; all state changes on rising edge
  reset, input, 1, asynchronous active-high reset
  cyc, input, 1, Wishbone bus cycle valid
  stb, input, 1, Wishbone strobe
  we, input, 1, 1 = write, 0 = read
  sel, input, DATA_W/8, byte lane enables for writes
  core_select, input, max(1,$clog2(NUM_BANKS)), bank index
  ADR_I, input, ADDR_W, word address
  DAT_I, input, DATA_W, write data
  DAT_O, output, DATA_W, read data
  ack, output, 1, normal termination
  err, output, 1, error termination

Function
REQ-003 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-004 In IDLE with cyc&stb sampled high, the block SHALL latch ADR_I, core_select, we, sel and DAT_I; it goes to WAIT loaded with WAIT_CYC, or to RESP directly when WAIT_CYC=0.
REQ-005 WAIT SHALL decrement its counter each cycle and go to RESP when the counter reaches 1.
REQ-006 ack or err SHALL be high only in RESP, only while cyc&stb are high, and for exactly one cycle; ack and err SHALL never both be high.
REQ-007 Latency SHALL be 1+WAIT_CYC cycles from the IDLE sampling edge to ack; with stb held, throughput SHALL be one transfer per 2+WAIT_CYC cycles.
REQ-008 A write SHALL commit to bank[core_select][ADR_I] on the edge ending RESP, and only to byte lanes with sel=1; sel=0 SHALL still ack with no change.
REQ-009 For reads, DAT_O SHALL present the full addressed word, ignoring sel, while ack is high, and SHALL hold the last read value otherwise.
REQ-010 ADR_I>=DEPTH or core_select>=NUM_BANKS SHALL produce err instead of ack after the normal latency; memory and DAT_O SHALL be unchanged.
REQ-011 cyc low in WAIT or RESP SHALL abort to IDLE: no ack, no err, no write.
REQ-012 RESP SHALL always return to IDLE; a new request is accepted there no earlier than the following edge.
REQ-013 Banks SHALL be fully independent; the same address in different banks holds different words.

Reset
REQ-014 reset high SHALL immediately force: state IDLE, wait counter 0, ack 0, err 0, DAT_O 0.
REQ-015 Reset mid-transaction SHALL abort it with no write; memory contents SHALL NOT be cleared and are undefined after power-up.

Structure
REQ-016 Package wb_mem_pkg SHALL hold the FSM state enum, the default parameter constants, and the bank-index-width function.
REQ-017 Sub-module wb_mem_bank (single-port byte-enabled synchronous RAM, DEPTH x DATA_W) SHALL be instantiated NUM_BANKS times via generate.

Verification
REQ-018 The bench SHALL cover these directed scenarios (stimulus -> required response):
  1. WAIT_CYC=1: write 0xDEADBEEF to bank 0, address 5, sel 4'hF, then read it back -> ack 2 cycles after each request; DAT_O=0xDEADBEEF.
  2. Write 0x11111111 to bank 0 address 3 and 0x22222222 to bank 1 address 3, then read both -> 0x11111111 and 0x22222222.
  3. Write 0xAABBCCDD with sel 4'b0101 over a zeroed word -> read returns 0x00BB00DD.
  4. Access address 256 (DEPTH=256) or core_select=2 (NUM_BANKS=2) -> err for one cycle, ack 0, target memory unchanged.
  5. WAIT_CYC=3: drop cyc in WAIT -> no ack, write absent on readback; assert reset in WAIT -> all outputs 0 at once, FSM in IDLE.
  6. Hold stb for 4 consecutive reads with WAIT_CYC=0 -> 4 acks, 2 cycles apart, each with the correct data.
